// File: rtl/vw_work_mailbox.sv
// vw_work_mailbox
// Command sequencer for the JTAG source/probe virtual wire. Host commands
// arrive as a toggle handshake on vw_source and load a staging work buffer,
// commit it to the hasher, or pop the golden-nonce FIFO. Results go back on
// vw_probe. Probe layout, from MSB to LSB:
//   {ack_toggle, overflow, full, count[FIFO_AW:0], head_nonce[31:0]}
module vw_work_mailbox #(
   parameter int FIFO_AW       = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [38:0]          vw_source,
   output logic [FIFO_AW+35:0]  vw_probe,
   input  logic [31:0]          nonce_in,
   input  logic                 nonce_valid,
   output logic [255:0]         work_midstate,
   output logic [95:0]          work_data,
   output logic                 work_valid
);

   localparam int              DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW+1)'(DEPTH);
   localparam logic [7:0]      SETTLE_C = 8'(SETTLE_CYCLES);

   localparam logic [1:0] CMD_NOP    = 2'd0;
   localparam logic [1:0] CMD_WRITE  = 2'd1;
   localparam logic [1:0] CMD_COMMIT = 2'd2;
   localparam logic [1:0] CMD_POP    = 2'd3;

   typedef enum logic [2:0] {
      ST_PRIME  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_ACK    = 3'd4
   } state_t;

   state_t              state_r, state_s;
   logic                sync1_r, sync_r, last_r, ack_toggle_r;
   logic [7:0]          cnt_r;
   logic [1:0]          cmd_s;
   logic [3:0]          addr_s;
   logic [31:0]         data_s;
   logic                write_s, commit_s, pop_req_s, clr_ovf_s;
   logic [7:0][31:0]    stage_mid_r;
   logic [2:0][31:0]    stage_dat_r;
   logic [31:0]         mem_r [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_r, rd_ptr_r;
   logic [FIFO_AW:0]    count_r;
   logic                overflow_r;
   logic                full_s, empty_s, pop_s, push_s, ovf_set_s;
   logic [31:0]         head_s;
   logic [FIFO_AW+34:0] probe_r;

   assign cmd_s  = vw_source[37:36];
   assign addr_s = vw_source[35:32];
   assign data_s = vw_source[31:0];

   // Two-flop synchronizer for req_toggle; left unreset so it already holds the
   // host level when reset releases and PRIME can absorb a pre-existing toggle.
   always_ff @(posedge clk) begin
      sync1_r <= vw_source[38];
      sync_r  <= sync1_r;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= ST_PRIME;
      else       state_r <= state_s;
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_PRIME:  state_s = ST_IDLE;
         ST_IDLE:   begin
            if (sync_r != last_r) state_s = ST_SETTLE;
            else                  state_s = ST_IDLE;
         end
         ST_SETTLE: begin
            if (cnt_r <= 8'd1) state_s = ST_EXEC;
            else               state_s = ST_SETTLE;
         end
         ST_EXEC:   state_s = ST_ACK;
         ST_ACK:    state_s = ST_IDLE;
         default:   state_s = ST_PRIME;
      endcase
   end

   // FSM output decode: one-cycle command strobes while in EXEC.
   always_comb begin
      write_s   = 1'b0;
      commit_s  = 1'b0;
      pop_req_s = 1'b0;
      clr_ovf_s = 1'b0;
      if (state_r == ST_EXEC) begin
         case (cmd_s)
            CMD_NOP:    write_s  = 1'b0;
            CMD_WRITE:  write_s  = 1'b1;
            CMD_COMMIT: commit_s = 1'b1;
            CMD_POP:    begin
               pop_req_s = 1'b1;
               clr_ovf_s = addr_s[0];
            end
            default:    write_s  = 1'b0;
         endcase
      end else begin
         write_s = 1'b0;
      end
   end

   // Handshake bookkeeping: last handled toggle level, settle counter, ack toggle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_r       <= 1'b0;
         cnt_r        <= 8'd0;
         ack_toggle_r <= 1'b0;
      end else begin
         if (state_r == ST_PRIME || state_r == ST_ACK) last_r <= sync_r;
         if (state_r == ST_IDLE)        cnt_r <= SETTLE_C;
         else if (state_r == ST_SETTLE) cnt_r <= cnt_r - 8'd1;
         if (state_r == ST_ACK) ack_toggle_r <= ~ack_toggle_r;
      end
   end

   // Staging buffer writes and commit to the hasher-facing work registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_mid_r   <= '0;
         stage_dat_r   <= '0;
         work_midstate <= 256'd0;
         work_data     <= 96'd0;
         work_valid    <= 1'b0;
      end else begin
         if (write_s) begin
            if (!addr_s[3])              stage_mid_r[addr_s[2:0]] <= data_s;
            else if (addr_s[2:0] < 3'd3) stage_dat_r[addr_s[1:0]] <= data_s;
         end
         if (commit_s) begin
            work_midstate <= stage_mid_r;
            work_data     <= stage_dat_r;
         end
         work_valid <= commit_s;
      end
   end

   assign full_s    = (count_r == DEPTH_C);
   assign empty_s   = (count_r == '0);
   assign pop_s     = pop_req_s && !empty_s;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_s    = nonce_valid && (!full_s || pop_s);
   assign ovf_set_s = nonce_valid && full_s && !pop_s;
   assign head_s    = empty_s ? 32'd0 : mem_r[rd_ptr_r];

   // Nonce storage; contents are only visible through head_s, so no reset needed.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= nonce_in;
   end

   // FIFO pointers, occupancy and sticky overflow (set beats clear).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (FIFO_AW+1)'(1);
            2'b01:   count_r <= count_r - (FIFO_AW+1)'(1);
            default: count_r <= count_r;
         endcase
         if (ovf_set_s)      overflow_r <= 1'b1;
         else if (clr_ovf_s) overflow_r <= 1'b0;
      end
   end

   // Registered probe snapshot of the FIFO status, one clock behind the FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) probe_r <= '0;
      else       probe_r <= {overflow_r, full_s, count_r, head_s};
   end

   assign vw_probe = {ack_toggle_r, probe_r};

endmodule

// File: tb/tb_vw_work_mailbox.sv
// Directed testbench for vw_work_mailbox (FIFO_AW=4, SETTLE_CYCLES=4).
module tb_vw_work_mailbox;

   localparam int AW  = 4;
   localparam int LAT = 9;   // SETTLE_CYCLES + 5

   logic         clk = 1'b0;
   logic         reset;
   logic [38:0]  vw_source;
   logic [39:0]  vw_probe;
   logic [31:0]  nonce_in;
   logic         nonce_valid;
   logic [255:0] work_midstate;
   logic [95:0]  work_data;
   logic         work_valid;

   int   checks = 0;
   int   errors = 0;
   logic host_tog;
   logic exp_ack;

   vw_work_mailbox #(.FIFO_AW(AW), .SETTLE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .vw_source(vw_source), .vw_probe(vw_probe),
      .nonce_in(nonce_in), .nonce_valid(nonce_valid),
      .work_midstate(work_midstate), .work_data(work_data), .work_valid(work_valid)
   );

   always #5 clk = ~clk;

   // Issue one host command and wait (bounded) for the ack toggle.
   // nonce_edge>0 raises nonce_valid for exactly the edge with that index.
   task automatic do_cmd(input logic [1:0] cmd, input logic [3:0] addr, input logic [31:0] data,
                         input int nonce_edge, input logic [31:0] nonce_val,
                         output int lat, output int wv);
      host_tog  = ~host_tog;
      vw_source = {host_tog, cmd, addr, data};
      lat = -1;
      wv  = 0;
      for (int e = 1; e <= 40; e++) begin
         if (nonce_edge > 0 && e == nonce_edge) begin
            nonce_valid = 1'b1;
            nonce_in    = nonce_val;
         end
         @(posedge clk); #1;
         nonce_valid = 1'b0;
         if (work_valid) wv++;
         if (vw_probe[39] !== exp_ack) begin
            lat = e;
            break;
         end
      end
      if (lat > 0) exp_ack = ~exp_ack;
   endtask

   task automatic test_reset;
      int acks;
      reset = 1'b1; vw_source = {1'b1, 38'd0}; host_tog = 1'b1; exp_ack = 1'b0;
      nonce_valid = 1'b0; nonce_in = 32'd0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (vw_probe[39] !== 1'b0) acks++;
      end
      checks++; if (acks !== 0) begin errors++; $display("FAIL reset_no_ack got %0d want 0", acks); end
      checks++; if (vw_probe !== 40'd0) begin errors++; $display("FAIL reset_probe got %h want 0", vw_probe); end
      checks++; if (work_midstate !== 256'd0 || work_data !== 96'd0 || work_valid !== 1'b0) begin
         errors++; $display("FAIL reset_work got %h/%h/%b want 0", work_midstate, work_data, work_valid); end
   endtask

   task automatic test_write_commit;
      int lat, wv;
      do_cmd(2'd1, 4'd0, 32'hDEADBEEF, 0, 32'd0, lat, wv);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL write_latency got %0d want %0d", lat, LAT); end
      do_cmd(2'd2, 4'd0, 32'd0, 0, 32'd0, lat, wv);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL commit_latency got %0d want %0d", lat, LAT); end
      checks++; if (wv !== 1) begin errors++; $display("FAIL commit_valid_width got %0d want 1", wv); end
      checks++; if (work_midstate !== {224'd0, 32'hDEADBEEF}) begin
         errors++; $display("FAIL commit_midstate got %h want %h", work_midstate, {224'd0, 32'hDEADBEEF}); end
   endtask

   task automatic test_data_words;
      int lat, wv;
      do_cmd(2'd1, 4'd9,  32'h12345678, 0, 32'd0, lat, wv);
      do_cmd(2'd1, 4'd13, 32'hFFFFFFFF, 0, 32'd0, lat, wv);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL ignored_addr_ack got %0d want %0d", lat, LAT); end
      do_cmd(2'd1, 4'd10, 32'hA5A5A5A5, 0, 32'd0, lat, wv);
      do_cmd(2'd1, 4'd7,  32'h77777777, 0, 32'd0, lat, wv);
      do_cmd(2'd1, 4'd11, 32'h0000BAD1, 0, 32'd0, lat, wv);
      do_cmd(2'd2, 4'd0,  32'd0,        0, 32'd0, lat, wv);
      checks++; if (work_data !== {32'hA5A5A5A5, 32'h12345678, 32'h00000000}) begin
         errors++; $display("FAIL data_words got %h want %h", work_data, {32'hA5A5A5A5, 32'h12345678, 32'h0}); end
      checks++; if (work_midstate !== {32'h77777777, 192'd0, 32'hDEADBEEF}) begin
         errors++; $display("FAIL midstate_words got %h want %h", work_midstate, {32'h77777777, 192'd0, 32'hDEADBEEF}); end
   endtask

   task automatic test_fifo_overflow;
      int lat, wv;
      for (int i = 1; i <= 17; i++) begin
         nonce_valid = 1'b1; nonce_in = 32'(i);
         @(posedge clk); #1;
      end
      nonce_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      checks++; if (vw_probe[38:0] !== {1'b1, 1'b1, 5'd16, 32'd1}) begin
         errors++; $display("FAIL fifo_full_state got %h want %h", vw_probe[38:0], {1'b1, 1'b1, 5'd16, 32'd1}); end
      do_cmd(2'd3, 4'd0, 32'd0, 0, 32'd0, lat, wv);
      checks++; if (vw_probe[38:0] !== {1'b1, 1'b0, 5'd15, 32'd2}) begin
         errors++; $display("FAIL pop_keep_ovf got %h want %h", vw_probe[38:0], {1'b1, 1'b0, 5'd15, 32'd2}); end
      do_cmd(2'd3, 4'd1, 32'd0, 0, 32'd0, lat, wv);
      checks++; if (vw_probe[38:0] !== {1'b0, 1'b0, 5'd14, 32'd3}) begin
         errors++; $display("FAIL pop_clear_ovf got %h want %h", vw_probe[38:0], {1'b0, 1'b0, 5'd14, 32'd3}); end
   endtask

   task automatic test_push_pop_full;
      int lat, wv, bad_lat;
      for (int i = 18; i <= 19; i++) begin
         nonce_valid = 1'b1; nonce_in = 32'(i);
         @(posedge clk); #1;
      end
      nonce_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      // EXEC edge of the POP is edge 8 after the request toggle.
      do_cmd(2'd3, 4'd0, 32'd0, 8, 32'd100, lat, wv);
      checks++; if (vw_probe[38:0] !== {1'b0, 1'b1, 5'd16, 32'd4}) begin
         errors++; $display("FAIL push_pop_full got %h want %h", vw_probe[38:0], {1'b0, 1'b1, 5'd16, 32'd4}); end
      bad_lat = 0;
      for (int i = 0; i < 15; i++) begin
         do_cmd(2'd3, 4'd0, 32'd0, 0, 32'd0, lat, wv);
         if (lat != LAT) bad_lat++;
      end
      checks++; if (bad_lat !== 0) begin errors++; $display("FAIL drain_latency got %0d bad want 0", bad_lat); end
      checks++; if (vw_probe[38:0] !== {1'b0, 1'b0, 5'd1, 32'd100}) begin
         errors++; $display("FAIL tail_nonce got %h want %h", vw_probe[38:0], {1'b0, 1'b0, 5'd1, 32'd100}); end
   endtask

   task automatic test_empty_and_abort;
      int lat, wv, acks, pulses;
      do_cmd(2'd3, 4'd0, 32'd0, 0, 32'd0, lat, wv);
      do_cmd(2'd3, 4'd0, 32'd0, 0, 32'd0, lat, wv);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL pop_empty_ack got %0d want %0d", lat, LAT); end
      checks++; if (vw_probe[38:0] !== 39'd0) begin
         errors++; $display("FAIL pop_empty_state got %h want 0", vw_probe[38:0]); end
      // COMMIT request aborted by reset while the FSM is settling.
      host_tog  = ~host_tog;
      vw_source = {host_tog, 2'd2, 4'd0, 32'd0};
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      exp_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      acks = 0; pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (vw_probe[39] !== 1'b0) acks++;
         if (work_valid) pulses++;
      end
      checks++; if (acks !== 0 || pulses !== 0) begin
         errors++; $display("FAIL abort_in_settle got ack %0d valid %0d want 0 0", acks, pulses); end
      checks++; if (work_midstate !== 256'd0) begin
         errors++; $display("FAIL abort_midstate got %h want 0", work_midstate); end
      do_cmd(2'd0, 4'd0, 32'd0, 0, 32'd0, lat, wv);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL reissue_latency got %0d want %0d", lat, LAT); end
      do_cmd(2'd1, 4'd3, 32'h0BADF00D, 0, 32'd0, lat, wv);
      do_cmd(2'd2, 4'd0, 32'd0, 0, 32'd0, lat, wv);
      checks++; if (work_midstate !== {128'd0, 32'h0BADF00D, 96'd0} || wv !== 1) begin
         errors++; $display("FAIL post_reset_commit got %h/%0d want %h/1", work_midstate, wv, {128'd0, 32'h0BADF00D, 96'd0}); end
   endtask

   initial begin
      test_reset;
      test_write_commit;
      test_data_words;
      test_fifo_overflow;
      test_push_pop_full;
      test_empty_and_abort;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
